// File: rtl/rx_frame_pkg.sv
// Shared types and elaboration-time helpers for the oversampling serial receiver.
package rx_frame_pkg;

   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} rx_state_e;

   function automatic int unsigned calc_div(input int unsigned clk_hz,
                                            input int unsigned sample_hz);
      return clk_hz / sample_hz;
   endfunction

   // Bits needed to hold 0..n-1, never less than one.
   function automatic int unsigned idx_w(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   function automatic int unsigned div_cnt_w(input int unsigned div);
      return idx_w(div);
   endfunction

   function automatic int unsigned samp_cnt_w(input int unsigned spb);
      return idx_w(spb);
   endfunction

   // ones_cnt must reach spb itself, one more value than samp_cnt.
   function automatic int unsigned ones_cnt_w(input int unsigned spb);
      return idx_w(spb + 1);
   endfunction

   function automatic int unsigned bit_idx_w(input int unsigned data_w);
      return idx_w(data_w);
   endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// Free-running clock divider producing a one-cycle sample strobe every DIV clocks.
module sample_tick_gen
   import rx_frame_pkg::*;
#(
   parameter int unsigned DIV = 10
) (
   input  logic CLOCK_50,
   input  logic RESET_N,
   input  logic en,
   output logic sample_tick
);

   localparam int unsigned CntW = div_cnt_w(DIV);
   localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);

   logic [CntW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (!en) begin
         cnt_d = '0;
      end else if (cnt_q == CntMax) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CntW'(1);
      end
   end

   // Gated by en so a stale terminal count cannot strobe while disabled.
   assign sample_tick = en && (cnt_q == CntMax);

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/rx_frame_sampler.sv
// Oversampling serial frame receiver: start detect, per-bit majority vote, stop check,
// registered data word with one-cycle valid / framing-error strobes.
module rx_frame_sampler
   import rx_frame_pkg::*;
#(
   parameter int unsigned CLK_HZ          = 50000000,
   parameter int unsigned SAMPLE_HZ       = 40000,
   parameter int unsigned SAMPLES_PER_BIT = 10,
   parameter int unsigned DATA_W          = 8
) (
   input  logic              CLOCK_50,
   input  logic              RESET_N,
   input  logic              en,
   input  logic              rx_in,
   output logic [DATA_W-1:0] data_out,
   output logic              data_valid,
   output logic              frame_err,
   output logic              busy,
   output logic              sample_tick
);

   localparam int unsigned Div   = calc_div(CLK_HZ, SAMPLE_HZ);
   localparam int unsigned SampW = samp_cnt_w(SAMPLES_PER_BIT);
   localparam int unsigned OnesW = ones_cnt_w(SAMPLES_PER_BIT);
   localparam int unsigned IdxW  = bit_idx_w(DATA_W);

   localparam logic [SampW-1:0] SampLast = SampW'(SAMPLES_PER_BIT - 1);
   localparam logic [IdxW-1:0]  IdxLast  = IdxW'(DATA_W - 1);

   if (Div < 2) begin : g_bad_div
      $error("rx_frame_sampler: CLK_HZ/SAMPLE_HZ must be at least 2");
   end
   if (SAMPLES_PER_BIT < 3) begin : g_bad_spb
      $error("rx_frame_sampler: SAMPLES_PER_BIT must be at least 3");
   end
   if (DATA_W < 1 || DATA_W > 32) begin : g_bad_dw
      $error("rx_frame_sampler: DATA_W must be in 1..32");
   end

   logic tick;

   sample_tick_gen #(
      .DIV (Div)
   ) u_tick_gen (
      .CLOCK_50    (CLOCK_50),
      .RESET_N     (RESET_N),
      .en          (en),
      .sample_tick (tick)
   );

   // Two-flop synchroniser, free running regardless of en; idles high.
   logic [1:0] sync_q, sync_d;
   logic       rx_s;

   assign sync_d = {sync_q[0], rx_in};
   assign rx_s   = sync_q[1];

   rx_state_e         state_q, state_d;
   logic [SampW-1:0]  samp_q, samp_d;
   logic [OnesW-1:0]  ones_q, ones_d;
   logic [IdxW-1:0]   idx_q, idx_d;
   logic [DATA_W-1:0] shreg_q, shreg_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              dv_q, dv_d;
   logic              fe_q, fe_d;

   logic [OnesW-1:0]  ones_new;
   logic              bit_end;
   logic              vote;

   always_comb begin
      state_d  = state_q;
      samp_d   = samp_q;
      ones_d   = ones_q;
      idx_d    = idx_q;
      shreg_d  = shreg_q;
      data_d   = data_q;
      dv_d     = 1'b0;
      fe_d     = 1'b0;
      ones_new = ones_q + OnesW'(rx_s);
      bit_end  = (samp_q == SampLast);
      // Strict majority: a tie votes 0.
      vote     = ((32'(ones_new) << 1) > SAMPLES_PER_BIT);

      if (!en) begin
         state_d = StIdle;
         samp_d  = '0;
         ones_d  = '0;
         idx_d   = '0;
         shreg_d = '0;
      end else if (tick) begin
         if (state_q == StIdle) begin
            // The detecting sample is start sample 0, known to be a zero.
            if (!rx_s) begin
               state_d = StStart;
               samp_d  = SampW'(1);
               ones_d  = '0;
            end
         end else if (!bit_end) begin
            samp_d = samp_q + SampW'(1);
            ones_d = ones_new;
         end else begin
            samp_d = '0;
            ones_d = '0;
            unique case (state_q)
               StStart: begin
                  if (vote) begin
                     state_d = StIdle;
                  end else begin
                     state_d = StData;
                     idx_d   = '0;
                  end
               end
               StData: begin
                  shreg_d[idx_q] = vote;
                  if (idx_q == IdxLast) begin
                     state_d = StStop;
                     idx_d   = '0;
                  end else begin
                     idx_d = idx_q + IdxW'(1);
                  end
               end
               StStop: begin
                  if (vote) begin
                     data_d = shreg_q;
                     dv_d   = 1'b1;
                  end else begin
                     fe_d = 1'b1;
                  end
                  state_d = StIdle;
               end
               default: begin
                  state_d = StIdle;
               end
            endcase
         end
      end
   end

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         sync_q  <= 2'b11;
         state_q <= StIdle;
         samp_q  <= '0;
         ones_q  <= '0;
         idx_q   <= '0;
         shreg_q <= '0;
         data_q  <= '0;
         dv_q    <= 1'b0;
         fe_q    <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         state_q <= state_d;
         samp_q  <= samp_d;
         ones_q  <= ones_d;
         idx_q   <= idx_d;
         shreg_q <= shreg_d;
         data_q  <= data_d;
         dv_q    <= dv_d;
         fe_q    <= fe_d;
      end
   end

   assign data_out    = data_q;
   assign data_valid  = dv_q;
   assign frame_err   = fe_q;
   // Disabling forces IDLE on the next edge; report not-busy already in that cycle.
   assign busy        = en && (state_q != StIdle);
   assign sample_tick = tick;

endmodule

// File: tb/tb_rx_frame_sampler.sv
// Directed and randomized frames against a sample-level majority-vote reference model.
module tb_rx_frame_sampler;

   localparam int unsigned Div = 10;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic en1   = 1'b0;
   logic en2   = 1'b0;
   logic rx1   = 1'b1;
   logic rx2   = 1'b1;

   logic [7:0]  dout1;
   logic        dv1, fe1, busy1, tick1;
   logic [11:0] dout2;
   logic        dv2, fe2, busy2, tick2;

   always #5 clk = ~clk;

   rx_frame_sampler #(
      .CLK_HZ          (1000),
      .SAMPLE_HZ       (100),
      .SAMPLES_PER_BIT (10),
      .DATA_W          (8)
   ) u_dut8 (
      .CLOCK_50    (clk),
      .RESET_N     (rst_n),
      .en          (en1),
      .rx_in       (rx1),
      .data_out    (dout1),
      .data_valid  (dv1),
      .frame_err   (fe1),
      .busy        (busy1),
      .sample_tick (tick1)
   );

   rx_frame_sampler #(
      .CLK_HZ          (1000),
      .SAMPLE_HZ       (100),
      .SAMPLES_PER_BIT (4),
      .DATA_W          (12)
   ) u_dut12 (
      .CLOCK_50    (clk),
      .RESET_N     (rst_n),
      .en          (en2),
      .rx_in       (rx2),
      .data_out    (dout2),
      .data_valid  (dv2),
      .frame_err   (fe2),
      .busy        (busy2),
      .sample_tick (tick2)
   );

   int compared   = 0;
   int mismatched = 0;
   int dv_cnt[2];
   int fe_cnt[2];
   int exp_dv[2];
   int exp_fe[2];
   logic [31:0] exp_data[2];

   initial begin
      dv_cnt = '{0, 0};
      fe_cnt = '{0, 0};
   end

   always @(negedge clk) begin
      if (dv1) dv_cnt[0]++;
      if (dv2) dv_cnt[1]++;
      if (fe1) fe_cnt[0]++;
      if (fe2) fe_cnt[1]++;
   end

   function automatic logic [31:0] dout_of(input int u);
      return (u == 0) ? 32'(dout1) : 32'(dout2);
   endfunction
   function automatic logic dv_of(input int u);
      return (u == 0) ? dv1 : dv2;
   endfunction
   function automatic logic fe_of(input int u);
      return (u == 0) ? fe1 : fe2;
   endfunction
   function automatic logic busy_of(input int u);
      return (u == 0) ? busy1 : busy2;
   endfunction
   function automatic logic tick_of(input int u);
      return (u == 0) ? tick1 : tick2;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic set_rx(input int u, input logic v);
      if (u == 0) rx1 = v;
      else rx2 = v;
   endtask

   // Hold line value for n sample periods; always starts and ends just after a tick edge.
   task automatic send_raw(input int u, input logic v, input int n);
      set_rx(u, v);
      repeat (n * Div) @(negedge clk);
   endtask

   task automatic idle(input int n);
      rx1 = 1'b1;
      rx2 = 1'b1;
      repeat (n * Div) @(negedge clk);
   endtask

   // noise: samples inverted per bit; tie_bit: data bit that gets exactly spb/2 inverted.
   task automatic send_frame(input int u, input logic [31:0] word, input int noise,
                             input bit stop_val, input int tie_bit, input string tag);
      int          dw, spb, n, placed, pos, ones, nbits, last;
      bit          v, vote, exp_ok;
      bit          smp[$];
      logic [31:0] mask, exp_word;
      dw    = (u == 0) ? 8 : 12;
      spb   = (u == 0) ? 10 : 4;
      nbits = dw + 2;
      for (int b = 0; b < nbits; b++) begin
         if (b == 0) v = 1'b0;
         else if (b == nbits - 1) v = stop_val;
         else v = word[b-1];
         n      = (b - 1 == tie_bit) ? spb / 2 : noise;
         mask   = '0;
         placed = 0;
         while (placed < n) begin
            pos = int'($urandom_range(spb - 1, (b == 0) ? 1 : 0));
            if (!mask[pos]) begin
               mask[pos] = 1'b1;
               placed++;
            end
         end
         for (int k = 0; k < spb; k++) smp.push_back(v ^ mask[k]);
      end

      exp_word = '0;
      exp_ok   = 1'b0;
      for (int b = 0; b < nbits; b++) begin
         ones = 0;
         for (int k = 0; k < spb; k++) ones += int'(smp[b * spb + k]);
         vote = (2 * ones > spb);
         if (b >= 1 && b <= dw) exp_word[b-1] = vote;
         if (b == nbits - 1) exp_ok = vote;
      end

      last = smp.size() - 1;
      for (int i = 0; i <= last; i++) begin
         set_rx(u, smp[i]);
         if (i == 0) begin
            repeat (Div - 1) @(negedge clk);
            check({tag, "_tick"}, 32'(tick_of(u)), 32'd1);
            @(negedge clk);
         end else begin
            repeat (Div) @(negedge clk);
         end
         if (i == last) begin
            check({tag, "_dv"}, 32'(dv_of(u)), 32'(exp_ok));
            check({tag, "_fe"}, 32'(fe_of(u)), 32'(!exp_ok));
            check({tag, "_busy_end"}, 32'(busy_of(u)), 32'd0);
         end else begin
            check({tag, "_busy"}, 32'(busy_of(u)), 32'd1);
         end
      end

      set_rx(u, 1'b1);
      if (exp_ok) exp_data[u] = exp_word;
      exp_dv[u] += int'(exp_ok);
      exp_fe[u] += int'(!exp_ok);
      @(negedge clk);
      #1;
      check({tag, "_dv_off"}, 32'(dv_of(u)), 32'd0);
      check({tag, "_fe_off"}, 32'(fe_of(u)), 32'd0);
      check({tag, "_data"}, dout_of(u), exp_data[u]);
      check({tag, "_ndv"}, 32'(dv_cnt[u]), 32'(exp_dv[u]));
      check({tag, "_nfe"}, 32'(fe_cnt[u]), 32'(exp_fe[u]));
      repeat (Div - 1) @(negedge clk);
   endtask

   initial begin
      exp_data = '{32'h0, 32'h0};
      exp_dv   = '{0, 0};
      exp_fe   = '{0, 0};

      repeat (3) @(negedge clk);
      check("rst_data", dout_of(0), 32'h0);
      check("rst_busy", 32'(busy1), 32'd0);
      check("rst_dv", 32'(dv1), 32'd0);
      check("rst_tick", 32'(tick1), 32'd0);
      rst_n = 1'b1;
      en1   = 1'b1;
      en2   = 1'b1;
      idle(3);

      send_frame(0, 32'hA5, 0, 1'b1, -1, "clean_a5");
      send_frame(0, 32'h3C, 4, 1'b1, -1, "noisy_3c");
      send_frame(0, 32'h3C, 0, 1'b1, 2, "tie_3c");
      check("tie_const", dout_of(0), 32'h38);

      // Glitch: 3 low samples then high; false start resolves at the 10th sample.
      send_raw(0, 1'b0, 3);
      check("glitch_busy_a", 32'(busy1), 32'd1);
      send_raw(0, 1'b1, 6);
      check("glitch_busy_b", 32'(busy1), 32'd1);
      send_raw(0, 1'b1, 1);
      check("glitch_busy_c", 32'(busy1), 32'd0);
      idle(2);
      #1;
      check("glitch_data", dout_of(0), exp_data[0]);
      check("glitch_ndv", 32'(dv_cnt[0]), 32'(exp_dv[0]));
      check("glitch_nfe", 32'(fe_cnt[0]), 32'(exp_fe[0]));

      send_frame(0, 32'hA5, 0, 1'b1, -1, "pre_bad");
      send_frame(0, 32'h12, 0, 1'b0, -1, "bad_stop");
      check("bad_keep", dout_of(0), 32'hA5);

      // Reset pulse in the middle of the data bits.
      send_raw(0, 1'b0, 10);
      send_raw(0, 1'b1, 10);
      send_raw(0, 1'b0, 5);
      check("mid_busy", 32'(busy1), 32'd1);
      rst_n = 1'b0;
      rx1   = 1'b1;
      #1;
      exp_data = '{32'h0, 32'h0};
      check("rstmid_data", dout_of(0), 32'h0);
      check("rstmid_busy", 32'(busy1), 32'd0);
      check("rstmid_dv", 32'(dv1), 32'd0);
      check("rstmid_data12", dout_of(1), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      idle(2);
      check("rstmid_ndv", 32'(dv_cnt[0]), 32'(exp_dv[0]));
      send_frame(0, 32'h5A, 0, 1'b1, -1, "after_rst");

      // en dropped mid-frame for 20 clocks.
      send_raw(0, 1'b0, 10);
      send_raw(0, 1'b1, 20);
      en1 = 1'b0;
      rx1 = 1'b1;
      #1;
      check("endrop_busy", 32'(busy1), 32'd0);
      repeat (20) @(negedge clk);
      check("endrop_tick", 32'(tick1), 32'd0);
      check("endrop_busy2", 32'(busy1), 32'd0);
      en1 = 1'b1;
      idle(2);
      #1;
      check("endrop_ndv", 32'(dv_cnt[0]), 32'(exp_dv[0]));
      check("endrop_nfe", 32'(fe_cnt[0]), 32'(exp_fe[0]));
      check("endrop_keep", dout_of(0), 32'h5A);
      send_frame(0, 32'h81, 0, 1'b1, -1, "after_en");

      for (int r = 0; r < 6; r++) begin
         send_frame(0, 32'($urandom_range(255, 0)), int'($urandom_range(4, 0)),
                    ($urandom_range(2, 0) != 0), -1, "rand8");
      end

      send_frame(1, 32'hABC, 0, 1'b1, -1, "w12_abc");
      for (int r = 0; r < 3; r++) begin
         send_frame(1, 32'($urandom_range(4095, 0)), int'($urandom_range(1, 0)), 1'b1, -1,
                    "rand12");
      end
      check("w12_nfe_total", 32'(fe_cnt[1]), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
